// File: rtl/matrix_pkg.sv
// Shared types and width helpers for the sequential matrix multiplier
// and the display stage that consumes its result.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result element width: full product plus room for N-term accumulation.
  function automatic int cw_of(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge detector for the divided step clock; one clk-wide pulse
// per step edge, usable by any block paced off the step clock.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic step_pulse
);

  logic step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  assign step_pulse = step & ~step_q;

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential unsigned NxN matrix multiplier: one MAC per step pulse,
// operands latched at capture, results exposed row-major as they finish.
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int W  = 4,
  localparam int CW = cw_of(N, W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              start,
  input  logic [N*N*W-1:0]  a_flat,
  input  logic [N*N*W-1:0]  b_flat,
  output logic [N*N*CW-1:0] c_flat,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state, state_d;

  logic              step_pulse;
  logic              capture;
  logic              mac;
  logic              last_term;
  logic [IW-1:0]     i, j, k;
  logic [CW-1:0]     acc;
  logic [N*N*W-1:0]  a_q, b_q;
  logic [N*N*CW-1:0] c_q;
  logic [W-1:0]      a_el, b_el;
  logic [2*W-1:0]    prod;
  logic [CW-1:0]     sum;

  step_edge_detect u_step (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .step_pulse (step_pulse)
  );

  assign a_el = a_q[(int'(i) * N + int'(k)) * W +: W];
  assign b_el = b_q[(int'(k) * N + int'(j)) * W +: W];
  assign prod = {{W{1'b0}}, a_el} * {{W{1'b0}}, b_el};
  assign sum  = acc + {{(CW - 2 * W){1'b0}}, prod};

  assign last_term = (i == LAST) && (j == LAST) && (k == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    capture = 1'b0;
    mac     = 1'b0;
    if (step_pulse) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            capture = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          mac = 1'b1;
          if (last_term) state_d = DONE;
        end
        DONE: begin
          if (!start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (capture) begin
      a_q <= a_flat;
      b_q <= b_flat;
      c_q <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (mac) begin
      if (k != LAST) begin
        acc <= sum;
        k   <= k + 1'b1;
      end else begin
        c_q[(int'(i) * N + int'(j)) * CW +: CW] <= sum;
        acc <= '0;
        k   <= '0;
        if (j == LAST) begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  assign c_flat = c_q;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq at N=2, W=4: vector table,
// random products against a nested-loop model, and multi-cycle corners.
module tb_matrix_mult_seq;

  localparam int N  = 2;
  localparam int W  = 4;
  localparam int CW = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              step;
  logic              start;
  logic [N*N*W-1:0]  a_flat;
  logic [N*N*W-1:0]  b_flat;
  logic [N*N*CW-1:0] c_flat;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  matrix_mult_seq #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .start  (start),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .c_flat (c_flat),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [N*N*W-1:0]  a;
    logic [N*N*W-1:0]  b;
    logic [N*N*CW-1:0] c;
  } vec_t;

  function automatic logic [15:0] pk4(int e0, int e1, int e2, int e3);
    return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  function automatic logic [35:0] pk9(int e0, int e1, int e2, int e3);
    return {9'(e3), 9'(e2), 9'(e1), 9'(e0)};
  endfunction

  // Textbook C[i][j] = sum_k A[i][k]*B[k][j] in plain integers.
  function automatic logic [35:0] ref_mult(logic [15:0] a, logic [15:0] b);
    int am [2][2];
    int bm [2][2];
    int cm [2][2];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        am[r][c] = int'(a[(r * 2 + c) * 4 +: 4]);
        bm[r][c] = int'(b[(r * 2 + c) * 4 +: 4]);
      end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        cm[r][c] = 0;
        for (int t = 0; t < 2; t++) cm[r][c] += am[r][t] * bm[t][c];
      end
    return pk9(cm[0][0], cm[0][1], cm[1][0], cm[1][1]);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(int hold);
    @(negedge clk);
    step = 1'b1;
    repeat (hold) @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulses(int n);
    for (int p = 0; p < n; p++) pulse(1);
  endtask

  task automatic capture(logic [15:0] a, logic [15:0] b, string name);
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    pulse(1);
    chk({name, " busy@cap"}, 64'(busy), 64'd1);
    chk({name, " c@cap"}, 64'(c_flat), 64'd0);
  endtask

  task automatic finish_run(logic [35:0] exp, string name);
    chk({name, " c"}, 64'(c_flat), 64'(exp));
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic to_idle(string name);
    start = 1'b0;
    pulse(1);
    chk({name, " idle"}, 64'({busy, done}), 64'd0);
  endtask

  vec_t tbl [4];
  logic [15:0] ra, rb, ref_a, ref_b;
  logic [35:0] ref_c, c_hold;

  initial begin
    ref_a = pk4(1, 2, 3, 4);
    ref_b = pk4(5, 6, 7, 8);
    ref_c = pk9(19, 22, 43, 50);
    tbl[0] = '{"ref",  ref_a, ref_b, ref_c};
    tbl[1] = '{"max",  pk4(15, 15, 15, 15), pk4(15, 15, 15, 15),
               pk9(450, 450, 450, 450)};
    tbl[2] = '{"ident", pk4(1, 0, 0, 1), pk4(9, 3, 12, 7),
               pk9(9, 3, 12, 7)};
    tbl[3] = '{"zero", pk4(0, 0, 0, 0), pk4(15, 15, 15, 15),
               pk9(0, 0, 0, 0)};

    rst = 1'b1; step = 1'b0; start = 1'b0;
    a_flat = '0; b_flat = '0;
    repeat (2) @(negedge clk);
    chk("reset c", 64'(c_flat), 64'd0);
    chk("reset busy/done", 64'({busy, done}), 64'd0);

    // Step already high at reset release must count as an edge.
    a_flat = ref_a; b_flat = ref_b; start = 1'b1; step = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("edge after reset busy", 64'(busy), 64'd1);
    step = 1'b0;
    pulses(8);
    finish_run(ref_c, "post-reset");
    to_idle("post-reset");

    foreach (tbl[v]) begin
      capture(tbl[v].a, tbl[v].b, tbl[v].name);
      pulses(7);
      chk({tbl[v].name, " busy@7"}, 64'(busy), 64'd1);
      pulse(1);
      finish_run(tbl[v].c, tbl[v].name);
      to_idle(tbl[v].name);
    end

    for (int r = 0; r < 6; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      capture(ra, rb, "rand");
      pulses(8);
      finish_run(ref_mult(ra, rb), "rand");
      to_idle("rand");
    end

    // One long step level must produce exactly one MAC.
    capture(ref_a, ref_b, "long");
    pulse(20);
    chk("long c00 pending", 64'(c_flat[8:0]), 64'd0);
    chk("long busy", 64'(busy), 64'd1);
    pulse(1);
    chk("long c00", 64'(c_flat[8:0]), 64'd19);
    pulses(6);
    finish_run(ref_c, "long");
    to_idle("long");

    // Operands are latched at capture only.
    capture(ref_a, ref_b, "opchg");
    pulses(3);
    a_flat = pk4(15, 15, 15, 15);
    b_flat = 16'($urandom);
    pulses(5);
    finish_run(ref_c, "opchg");
    to_idle("opchg");

    // Reset mid-run drops partial results.
    capture(pk4(15, 15, 15, 15), ref_b, "midrst");
    pulses(5);
    chk("midrst partial", 64'(c_flat != 0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst c", 64'(c_flat), 64'd0);
    chk("midrst busy/done", 64'({busy, done}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    capture(ref_a, ref_b, "after-rst");
    pulses(8);
    finish_run(ref_c, "after-rst");

    // DONE holds while start stays high; re-arm clears on capture.
    for (int p = 0; p < 3; p++) begin
      pulse(1);
      chk("hold done", 64'({busy, done}), 64'd1);
      chk("hold c", 64'(c_flat), 64'(ref_c));
    end
    c_hold = c_flat;
    to_idle("rearm");
    chk("rearm c kept", 64'(c_flat), 64'(ref_c));
    chk("rearm c stable", 64'(c_flat), 64'(c_hold));
    capture(pk4(1, 0, 0, 1), ref_b, "rearm2");
    pulses(8);
    finish_run(ref_b == 16'h8765 ? pk9(5, 6, 7, 8) : 36'd0, "rearm2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
